// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 sequencing/arbitration logic.
package fma16_pkg;

  localparam int unsigned NREQ = 2;

  // Operation control bits, MSB first: {mul, add, negp, negz}.
  typedef struct packed {
    logic mul;
    logic add;
    logic negp;
    logic negz;
  } fma16_op_t;

  // Exception flags, MSB first: {nv, of, uf, nx}.
  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fma16_flags_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_t;

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RN  = 2'b10;
  localparam logic [1:0] RM_RP  = 2'b11;

endpackage

// File: rtl/fma16_rr_arb.sv
// Two-way round-robin grant logic. On a tie the requester that did not win
// last time is granted; last_grant advances only when the grant is consumed.
module fma16_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_grant_q, last_grant_d;

  // Combinational grant selection and last-grant next state.
  always_comb begin
    gnt_valid    = |req;
    gnt_idx      = req[1];
    if (req == 2'b11) begin
      gnt_idx = ~last_grant_q;
    end
    last_grant_d = last_grant_q;
    if (update) begin
      last_grant_d = gnt_idx;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/fma16_arbiter.sv
// Shares one external fma16 datapath between two requesters: round-robin
// accept, operand registers, fixed-latency wait, held response, sticky flags.
module fma16_arbiter
  import fma16_pkg::*;
#(
  parameter int unsigned CORE_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0][15:0] req_x,
  input  logic [1:0][15:0] req_y,
  input  logic [1:0][15:0] req_z,
  input  logic [1:0][3:0] req_op,
  input  logic [1:0][1:0] req_rm,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [15:0]     rsp_result,
  output logic [3:0]      rsp_flags,
  output logic            rsp_id,
  output logic [15:0]     fma_x,
  output logic [15:0]     fma_y,
  output logic [15:0]     fma_z,
  output logic [3:0]      fma_op,
  output logic [1:0]      fma_rm,
  input  logic [15:0]     fma_result,
  input  logic [3:0]      fma_flags,
  output logic [3:0]      flags_acc,
  input  logic            flags_clr,
  output logic            busy
);

  localparam logic [2:0] LatInit = 3'(CORE_LAT - 1);

  arb_state_t   state_q, state_d;
  logic [15:0]  fma_x_q, fma_x_d, fma_y_q, fma_y_d, fma_z_q, fma_z_d;
  fma16_op_t    fma_op_q, fma_op_d;
  logic [1:0]   fma_rm_q, fma_rm_d;
  logic         id_q, id_d;
  logic [2:0]   lat_cnt_q, lat_cnt_d;
  logic [15:0]  rsp_result_q, rsp_result_d;
  fma16_flags_t rsp_flags_q, rsp_flags_d;
  logic         rsp_id_q, rsp_id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [3:0]   flags_acc_q, flags_acc_d;

  logic gnt_valid, gnt_idx;
  logic can_accept, accept, capture;

  fma16_rr_arb u_rr_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .update    (accept),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Handshake, FSM next state, operand load, response capture, sticky flags.
  always_comb begin
    state_d      = state_q;
    fma_x_d      = fma_x_q;
    fma_y_d      = fma_y_q;
    fma_z_d      = fma_z_q;
    fma_op_d     = fma_op_q;
    fma_rm_d     = fma_rm_q;
    id_d         = id_q;
    lat_cnt_d    = lat_cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    flags_acc_d  = flags_acc_q;
    req_ready    = 2'b00;

    // A new op may enter when idle, or when the held response drains this edge.
    can_accept = !reset && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
    if (can_accept && gnt_valid) begin
      req_ready[gnt_idx] = 1'b1;
    end
    accept  = |(req_valid & req_ready);
    capture = (state_q == StExec) && (lat_cnt_q == 3'd0);

    unique case (state_q)
      StIdle: ;
      StExec: begin
        if (capture) begin
          rsp_result_d = fma_result;
          rsp_flags_d  = fma_flags;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept overrides the RESP->IDLE transition for back-to-back ops.
    if (accept) begin
      fma_x_d   = req_x[gnt_idx];
      fma_y_d   = req_y[gnt_idx];
      fma_z_d   = req_z[gnt_idx];
      fma_op_d  = req_op[gnt_idx];
      fma_rm_d  = req_rm[gnt_idx];
      id_d      = gnt_idx;
      lat_cnt_d = LatInit;
      state_d   = StExec;
    end

    // A clear coinciding with a capture keeps the freshly captured flags.
    if (capture) begin
      flags_acc_d = flags_clr ? fma_flags : (flags_acc_q | fma_flags);
    end else if (flags_clr) begin
      flags_acc_d = 4'b0000;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      fma_x_q      <= '0;
      fma_y_q      <= '0;
      fma_z_q      <= '0;
      fma_op_q     <= '0;
      fma_rm_q     <= '0;
      id_q         <= 1'b0;
      lat_cnt_q    <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      flags_acc_q  <= '0;
    end else begin
      state_q      <= state_d;
      fma_x_q      <= fma_x_d;
      fma_y_q      <= fma_y_d;
      fma_z_q      <= fma_z_d;
      fma_op_q     <= fma_op_d;
      fma_rm_q     <= fma_rm_d;
      id_q         <= id_d;
      lat_cnt_q    <= lat_cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      flags_acc_q  <= flags_acc_d;
    end
  end

  assign fma_x      = fma_x_q;
  assign fma_y      = fma_y_q;
  assign fma_z      = fma_z_q;
  assign fma_op     = fma_op_q;
  assign fma_rm     = fma_rm_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_id     = rsp_id_q;
  assign flags_acc  = flags_acc_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fma16_arbiter.sv
// Directed bench for fma16_arbiter; the fma16 core is modelled by driving
// fma_result/fma_flags with hand-chosen values.
module tb_fma16_arbiter;
  import fma16_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic             reset;
  logic [1:0]       req_valid, req_ready;
  logic [1:0][15:0] req_x, req_y, req_z;
  logic [1:0][3:0]  req_op;
  logic [1:0][1:0]  req_rm;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [15:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic [15:0]      fma_x, fma_y, fma_z, fma_result;
  logic [3:0]       fma_op, fma_flags, flags_acc;
  logic [1:0]       fma_rm;
  logic             flags_clr, busy;

  // Second instance with CORE_LAT=3, own handshake signals.
  logic [1:0]  req_valid3, req_ready3;
  logic        rsp_valid3, rsp_ready3, rsp_id3, busy3;
  logic [15:0] rsp_result3, fma_x3, fma_y3, fma_z3;
  logic [3:0]  rsp_flags3, fma_op3, flags_acc3;
  logic [1:0]  fma_rm3;

  fma16_arbiter #(.CORE_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_op(req_op), .req_rm(req_rm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_id(rsp_id), .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_op(fma_op), .fma_rm(fma_rm), .fma_result(fma_result), .fma_flags(fma_flags),
    .flags_acc(flags_acc), .flags_clr(flags_clr), .busy(busy)
  );

  fma16_arbiter #(.CORE_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_op(req_op), .req_rm(req_rm),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_flags(rsp_flags3), .rsp_id(rsp_id3), .fma_x(fma_x3), .fma_y(fma_y3),
    .fma_z(fma_z3), .fma_op(fma_op3), .fma_rm(fma_rm3), .fma_result(fma_result),
    .fma_flags(fma_flags), .flags_acc(flags_acc3), .flags_clr(flags_clr), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Issue one op on requester r with CORE_LAT=1 core; flags_clr (if set) is
  // raised only for the capture edge.
  task automatic issue(input int r, input logic [15:0] res, input logic [3:0] fl,
                       input logic clr);
    int n;
    req_valid    = 2'b00;
    req_valid[r] = 1'b1;
    rsp_ready    = 1'b1;
    fma_result   = res;
    fma_flags    = fl;
    #1;
    n = 0;
    while (!req_ready[r] && n < 20) begin
      step();
      n++;
    end
    chk("iss_acc_timeout", 32'(n >= 20), 0);
    step();
    req_valid = 2'b00;
    flags_clr = clr;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      flags_clr = 1'b0;
      n++;
    end
    flags_clr = 1'b0;
    chk("iss_rsp_timeout", 32'(n >= 20), 0);
    chk("iss_res", rsp_result, res);
    chk("iss_flags", rsp_flags, fl);
    chk("iss_id", rsp_id, 32'(r));
    step();
  endtask

  logic [1:0] exp_rr [9];
  logic       exp_rv [9];
  logic       exp_id [9];

  initial begin
    exp_rr = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    exp_rv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_z = '0;
    req_op = '0; req_rm = '0; rsp_ready = 1'b0; fma_result = '0; fma_flags = '0;
    flags_clr = 1'b0; req_valid3 = '0; rsp_ready3 = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_flags_acc", flags_acc, 0);
    chk("rst_fma_x", fma_x, 0);
    chk("rst_req_ready", req_ready, 0);
    reset = 1'b0;

    // Single request: 1.0*2.0+1.0 = 3.0.
    req_x[0] = 16'h3C00; req_y[0] = 16'h4000; req_z[0] = 16'h3C00;
    req_op[0] = 4'b1100; req_rm[0] = RM_RNE;
    req_valid = 2'b01; rsp_ready = 1'b1; fma_result = 16'h4200; fma_flags = 4'b0000;
    #1;
    chk("t1_ready", req_ready, 2'b01);
    step();
    chk("t1_fma_x", fma_x, 16'h3C00);
    chk("t1_fma_y", fma_y, 16'h4000);
    chk("t1_fma_op", fma_op, 4'b1100);
    chk("t1_fma_rm", fma_rm, 2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_rv_early", rsp_valid, 0);
    req_valid = 2'b00;
    step();
    chk("t1_rv", rsp_valid, 1);
    chk("t1_res", rsp_result, 16'h4200);
    chk("t1_id", rsp_id, 0);
    chk("t1_flags", rsp_flags, 0);
    step();
    chk("t1_idle", busy, 0);

    // Both requesters continuously valid: alternate with no bubble.
    do_reset();
    req_x[1] = 16'h4400;
    req_valid = 2'b11;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("t2_rr", req_ready, exp_rr[i]);
      chk("t2_rv", rsp_valid, exp_rv[i]);
      if (exp_rv[i]) chk("t2_id", rsp_id, exp_id[i]);
      if (i > 0) chk("t2_busy", busy, 1);
      if (i == 8) req_valid = 2'b00;
      step();
    end
    step();

    // Response held while rsp_ready is low; pending req1 taken on release edge.
    do_reset();
    req_valid = 2'b01; rsp_ready = 1'b0; fma_result = 16'h4200; fma_flags = 4'b0001;
    step();
    req_valid = 2'b10;
    step();
    fma_result = 16'hBEEF; fma_flags = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_rv", rsp_valid, 1);
      chk("t3_res", rsp_result, 16'h4200);
      chk("t3_flags", rsp_flags, 4'b0001);
      chk("t3_id", rsp_id, 0);
      chk("t3_rr", req_ready, 2'b00);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_rr_rel", req_ready, 2'b10);
    step();
    chk("t3_fma_x", fma_x, 16'h4400);
    chk("t3_rv_clr", rsp_valid, 0);
    chk("t3_busy", busy, 1);
    req_valid = 2'b00;
    step();
    chk("t3_rv2", rsp_valid, 1);
    chk("t3_id2", rsp_id, 1);
    chk("t3_res2", rsp_result, 16'hBEEF);
    chk("t3_facc", flags_acc, 4'b1001);
    step();

    // Sticky flags accumulation and clear.
    do_reset();
    issue(0, 16'h3C00, 4'b0001, 1'b0);
    chk("t4_facc_nx", flags_acc, 4'b0001);
    issue(1, 16'h7C00, 4'b0100, 1'b0);
    chk("t4_facc_nx_of", flags_acc, 4'b0101);
    issue(0, 16'h3C01, 4'b0001, 1'b1);
    chk("t4_facc_clr_cap", flags_acc, 4'b0001);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    chk("t4_facc_clr", flags_acc, 4'b0000);

    // Reset while in EXEC discards the op.
    issue(1, 16'h3800, 4'b0010, 1'b0);
    chk("t5_facc_pre", flags_acc, 4'b0010);
    req_x[0] = 16'h3C00;
    req_valid = 2'b01; fma_flags = 4'b0100;
    step();
    chk("t5_exec", busy, 1);
    req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_rv", rsp_valid, 0);
    chk("t5_facc", flags_acc, 0);
    chk("t5_fma_x", fma_x, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_rsp", rsp_valid, 0);
    end

    // CORE_LAT=3: operands stable, response on the 3rd edge after accept.
    req_x[0] = 16'h3C00; req_valid3 = 2'b01; rsp_ready3 = 1'b1; fma_result = 16'h4500;
    fma_flags = 4'b0000;
    step();
    chk("t6_fma_x", fma_x3, 16'h3C00);
    chk("t6_rv0", rsp_valid3, 0);
    req_valid3 = 2'b00;
    req_x[0] = 16'h1234;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("t6_fma_x_hold", fma_x3, 16'h3C00);
      chk("t6_rv", rsp_valid3, 32'(i == 3));
    end
    chk("t6_res", rsp_result3, 16'h4500);
    chk("t6_id", rsp_id3, 0);
    step();
    chk("t6_idle", busy3, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
